right_shift_scheduler: RTL and testbench
========================================

# right_shift_scheduler

Sequential front-end that shares one 16-bit logical right-shift datapath (`out = a >> b`) between two independent requesters. It arbitrates round-robin and registers each result with the winning requester's ID. It presents the result downstream on a valid/ready output, with one-cycle latency and full backpressure. It sits between two compute lanes of the accelerator and the single shift unit they share.

## Interface
- WIDTH, 16, data width of operands and result; the shift amount uses the full WIDTH-bit `b` operand.
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- req0_valid  input  1  requester 0 has an operand pair
- req0_ready  output  1  requester 0 pair accepted this cycle
- req0_a  input  WIDTH  requester 0 value to shift
- req0_b  input  WIDTH  requester 0 shift amount
- req1_valid / req1_ready / req1_a / req1_b: same as above, for requester 1
- out_valid  output  1  result register holds a result
- out_ready  input  1  downstream consumes the result
- out  output  WIDTH  shifted result
- out_id  output  1  requester that produced `out` (0 or 1)

## Operation
- Shift rule: `out = a >> b`, logical, zero fill. Any `b >= WIDTH` gives 0, including when upper bits of `b` are set. `b = 0` passes `a` unchanged.
- can_accept = !out_valid || out_ready. At most one request is accepted per cycle.
- Arbitration uses a 1-bit priority pointer `prio`, which is 0 after reset.
  - Only one valid: that requester wins.
  - Both valid: requester `prio` wins.
- reqN_ready = can_accept && (requester N wins). It is combinational from the valid inputs, `out_valid` and `out_ready`. A requester whose valid is low never sees ready.
- On an accept (valid && ready):
  - `out` <= winner's a >> b.
  - `out_id` <= winner.
  - `out_valid` <= 1.
  - `prio` <= !winner. `prio` updates only on an accept.
- On a consume (out_valid && out_ready) with no accept in the same cycle: `out_valid` <= 0. `out` and `out_id` keep their last values.
- Simultaneous consume and accept: the register is overwritten with the new result, `out_valid` stays 1, and there is no bubble.
- Output state machine:
  - EMPTY (out_valid = 0) -> FULL when any valid is asserted.
  - FULL -> FULL when a consume and an accept happen together, or when out_ready = 0 (stall).
  - FULL -> EMPTY when a consume happens with no accept.
- Stall: while FULL and out_ready = 0, both readies are 0, and `out` / `out_id` hold stable.
- Requester rules: a requester must hold a, b and valid stable until it sees ready. The block does not check this.
- Reset: asynchronous assertion of rst_n clears `out_valid`, `out`, `out_id` and `prio` to 0 immediately, including mid-stall. A result pending at reset is discarded. Readies go to 0 combinationally until a valid is seen after reset release.

## Timing
- Latency: 1 cycle. A pair accepted at edge N appears on `out` with out_valid = 1 after edge N.
- Throughput: 1 result per cycle while out_ready = 1.
- Both requesters held valid with out_ready = 1: grants alternate 0, 1, 0, 1, ...
- Reset values: out_valid = 0, out = 0, out_id = 0, prio = 0. req0_ready and req1_ready are 0 whenever their valid is low.
- The only combinational paths are valid / out_ready -> ready. There is no path from out_ready to `out`.

## Test plan
- Single requester: req0 sends these pairs (a, b), with out_ready = 1.
  - Stimulus: (0x0007, 2), (0x0007, 1), (0x000F, 1), (0x003F, 5).
  - Required: out = 0x0001, 0x0003, 0x0007, 0x0001 on consecutive cycles, each with out_id = 0 and one-cycle latency.
- Edge shifts:
  - (0x8000, 15) -> 0x0001.
  - (0xFFFF, 0) -> 0xFFFF.
  - (0xFFFF, 16) -> 0x0000.
  - (0x1234, 0x0100) -> 0x0000.
- Contention: both requesters valid for 4 cycles, with out_ready = 1.
  - Stimulus: req0 = (0x00F0, 4), req1 = (0x0F00, 8).
  - Required: out_id sequence 0, 1, 0, 1 with out = 0x000F every cycle. `prio` returns to 0 afterwards.
- Backpressure: hold out_ready = 0 for 3 cycles while req1 is valid.
  - Required: out_valid stays 1, `out` and `out_id` are stable, and req1_ready = 0.
  - On release of out_ready, the held result is consumed and the req1 pair is accepted in the same cycle, with no bubble.
- Reset mid-operation: assert rst_n low while FULL and stalled.
  - Required: out_valid = 0 and out = 0 immediately.
  - After release with both requesters valid, req0 wins first.
- Idle drain: an accept followed by no valids, with out_ready = 1.
  - Required: out_valid goes 1 for exactly one cycle, then 0.
  - `out` retains the last value while out_valid = 0.

Source files
------------

// File: rtl/right_shift_scheduler_if.sv
// Handshake bundle between the two shift requesters, the shared
// shift unit front-end, and the downstream consumer.
interface right_shift_scheduler_if #(
   parameter int WIDTH = 16
);
   logic             req0_valid;
   logic             req0_ready;
   logic [WIDTH-1:0] req0_a;
   logic [WIDTH-1:0] req0_b;
   logic             req1_valid;
   logic             req1_ready;
   logic [WIDTH-1:0] req1_a;
   logic [WIDTH-1:0] req1_b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out;
   logic             out_id;

   modport master (
      output req0_valid, req0_a, req0_b,
      input  req0_ready,
      output req1_valid, req1_a, req1_b,
      input  req1_ready,
      input  out_valid, out, out_id,
      output out_ready
   );

   modport slave (
      input  req0_valid, req0_a, req0_b,
      output req0_ready,
      input  req1_valid, req1_a, req1_b,
      output req1_ready,
      output out_valid, out, out_id,
      input  out_ready
   );
endinterface

// File: rtl/right_shift_scheduler.sv
// Round-robin front-end sharing one logical right shifter between two
// requesters; one-cycle registered result with full backpressure.
module right_shift_scheduler #(
   parameter int WIDTH = 16
) (
   input logic                    clk,
   input logic                    rst_n,
   right_shift_scheduler_if.slave bus
);
   typedef enum logic {EMPTY, FULL} state_t;

   state_t           state_q;
   state_t           state_d;
   logic             prio_q;
   logic [WIDTH-1:0] out_q;
   logic             id_q;

   logic             out_valid;
   logic             can_accept;
   logic             any_valid;
   logic             win;
   logic             accept;
   logic [WIDTH-1:0] sh0;
   logic [WIDTH-1:0] sh1;

   assign out_valid  = (state_q == FULL);
   assign can_accept = !out_valid || bus.out_ready;
   assign any_valid  = bus.req0_valid || bus.req1_valid;
   assign accept     = can_accept && any_valid;

   // Contention goes to prio; a lone valid always wins.
   assign win = (bus.req0_valid && bus.req1_valid) ? prio_q
                                                   : bus.req1_valid;

   assign bus.req0_ready = can_accept && bus.req0_valid && !win;
   assign bus.req1_ready = can_accept && bus.req1_valid && win;

   // A WIDTH-bit shift amount >= WIDTH naturally yields zero.
   assign sh0 = bus.req0_a >> bus.req0_b;
   assign sh1 = bus.req1_a >> bus.req1_b;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         EMPTY: begin
            if (any_valid) state_d = FULL;
         end
         FULL: begin
            if (bus.out_ready && !any_valid) state_d = EMPTY;
         end
         default: state_d = EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q  <= '0;
         id_q   <= 1'b0;
         prio_q <= 1'b0;
      end else if (accept) begin
         out_q  <= win ? sh1 : sh0;
         id_q   <= win;
         prio_q <= !win;
      end
   end

   assign bus.out_valid = out_valid;
   assign bus.out       = out_q;
   assign bus.out_id    = id_q;
endmodule

// File: tb/tb_right_shift_scheduler.sv
// Directed bench for right_shift_scheduler: vector table for the
// shift rule plus sequences for contention, stall, reset and drain.
module tb_right_shift_scheduler;
   localparam int W = 16;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] exp;
   } vec_t;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;
   vec_t vecs [8];

   right_shift_scheduler_if #(.WIDTH(W)) bus ();

   right_shift_scheduler #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%0h exp=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set0(input logic v, input logic [W-1:0] a,
                       input logic [W-1:0] b);
      bus.req0_valid = v;
      bus.req0_a     = a;
      bus.req0_b     = b;
   endtask

   task automatic set1(input logic v, input logic [W-1:0] a,
                       input logic [W-1:0] b);
      bus.req1_valid = v;
      bus.req1_a     = a;
      bus.req1_b     = b;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      vecs[0] = '{16'h0007, 16'd2,    16'h0001};
      vecs[1] = '{16'h0007, 16'd1,    16'h0003};
      vecs[2] = '{16'h000F, 16'd1,    16'h0007};
      vecs[3] = '{16'h003F, 16'd5,    16'h0001};
      vecs[4] = '{16'hFFFF, 16'd16,   16'h0000};
      vecs[5] = '{16'h1234, 16'h0100, 16'h0000};
      vecs[6] = '{16'hFFFF, 16'd0,    16'hFFFF};
      vecs[7] = '{16'h8000, 16'd15,   16'h0001};

      rst_n = 1'b0;
      set0(1'b0, '0, '0);
      set1(1'b0, '0, '0);
      bus.out_ready = 1'b1;
      #12;
      chk("rst_out_valid", 32'(bus.out_valid), 0);
      chk("rst_out", 32'(bus.out), 0);
      chk("rst_out_id", 32'(bus.out_id), 0);
      chk("rst_ready0", 32'(bus.req0_ready), 0);
      chk("rst_ready1", 32'(bus.req1_ready), 0);
      rst_n = 1'b1;
      tick();

      // contention: grants alternate starting at requester 0
      set0(1'b1, 16'h00F0, 16'd4);
      set1(1'b1, 16'h0F00, 16'd8);
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("cont_ready0", 32'(bus.req0_ready), 32'(i % 2 == 0));
         chk("cont_ready1", 32'(bus.req1_ready), 32'(i % 2 == 1));
         if (i < 4) begin
            tick();
            chk("cont_out_valid", 32'(bus.out_valid), 1);
            chk("cont_out_id", 32'(bus.out_id), 32'(i % 2));
            chk("cont_out", 32'(bus.out), 32'h000F);
         end
      end
      set0(1'b0, '0, '0);
      set1(1'b0, '0, '0);

      // back-to-back table on requester 0
      for (int i = 0; i < 8; i++) begin
         tick();
         set0(1'b1, vecs[i].a, vecs[i].b);
         #1;
         chk("vec_ready0", 32'(bus.req0_ready), 1);
         tick();
         chk("vec_out_valid", 32'(bus.out_valid), 1);
         chk("vec_out", 32'(bus.out), 32'(vecs[i].exp));
         chk("vec_out_id", 32'(bus.out_id), 0);
         #0;
      end

      // idle drain
      set0(1'b0, '0, '0);
      tick();
      chk("drain_valid", 32'(bus.out_valid), 0);
      chk("drain_out", 32'(bus.out), 32'h0001);
      tick();
      chk("drain_valid2", 32'(bus.out_valid), 0);
      chk("drain_out2", 32'(bus.out), 32'h0001);

      // backpressure: fill while stalled, then hold req1 off
      bus.out_ready = 1'b0;
      set0(1'b1, 16'h0F00, 16'd4);
      tick();
      set0(1'b0, '0, '0);
      chk("bp_fill_valid", 32'(bus.out_valid), 1);
      chk("bp_fill_out", 32'(bus.out), 32'h00F0);
      set1(1'b1, 16'hFF00, 16'd8);
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("bp_ready1", 32'(bus.req1_ready), 0);
         chk("bp_valid", 32'(bus.out_valid), 1);
         chk("bp_out", 32'(bus.out), 32'h00F0);
         chk("bp_out_id", 32'(bus.out_id), 0);
         tick();
      end
      bus.out_ready = 1'b1;
      #1;
      chk("bp_rel_ready1", 32'(bus.req1_ready), 1);
      tick();
      chk("bp_rel_valid", 32'(bus.out_valid), 1);
      chk("bp_rel_out", 32'(bus.out), 32'h00FF);
      chk("bp_rel_out_id", 32'(bus.out_id), 1);

      // reset while full and stalled
      set1(1'b0, '0, '0);
      bus.out_ready = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(bus.out_valid), 0);
      chk("mid_rst_out", 32'(bus.out), 0);
      chk("mid_rst_out_id", 32'(bus.out_id), 0);
      set0(1'b1, 16'h00F0, 16'd4);
      set1(1'b1, 16'h0F00, 16'd8);
      bus.out_ready = 1'b1;
      #1;
      rst_n = 1'b1;
      #1;
      chk("post_rst_ready0", 32'(bus.req0_ready), 1);
      chk("post_rst_ready1", 32'(bus.req1_ready), 0);
      tick();
      chk("post_rst_out_id", 32'(bus.out_id), 0);
      chk("post_rst_out", 32'(bus.out), 32'h000F);
      #1;
      chk("post_rst_next1", 32'(bus.req1_ready), 1);
      set0(1'b0, '0, '0);
      set1(1'b0, '0, '0);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
